// File: rtl/spart_pkg.sv
// SPART bus interface shared definitions.
// Register map, status layout, reset divisor and TX states.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DIVL = 2'd2;
  localparam logic [1:0] ADDR_DIVH = 2'd3;

  localparam int ST_RDA = 0;
  localparam int ST_TBR = 1;
  localparam int ST_OVR = 2;

  localparam logic [15:0] DIV_DEFAULT = 16'h0144;

  typedef enum logic [1:0] {
    TX_EMPTY  = 2'd0,
    TX_LOADED = 2'd1,
    TX_ISSUE  = 2'd2
  } tx_state_e;

  function automatic logic [7:0] status_byte(
    input logic ovr,
    input logic tbr,
    input logic rda
  );
    logic [7:0] s;
    s         = 8'h00;
    s[ST_OVR] = ovr;
    s[ST_TBR] = tbr;
    s[ST_RDA] = rda;
    return s;
  endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// SPART baud generator: 16-bit down counter.
// Pulses baud_en_o at zero, period is divisor+1 cycles.
module spart_baud_gen
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] divisor_i,
  input  logic        reload_i,
  output logic        baud_en_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = divisor_i;
    end else if (cnt_q == 16'h0000) begin
      cnt_d = divisor_i;
    end else begin
      cnt_d = cnt_q - 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= DIV_DEFAULT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign baud_en_o = (cnt_q == 16'h0000);

endmodule

// File: rtl/spart_bus_if.sv
// SPART processor-side bus interface: register file,
// TX hand-off FSM, RX buffer with overrun, baud generator.
module spart_bus_if
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       baud_en
);

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  rxbuf_q, rxbuf_d;
  logic        rda_q, rda_d;
  logic        ovr_q, ovr_d;
  logic [15:0] div_q, div_d;
  logic        reload;
  logic        wr_en;
  logic        rd_en;
  logic        rd_data_sel;
  logic        rd_stat_sel;
  logic        ovr_set;
  logic [7:0]  rd_data;

  assign wr_en       = iocs & ~iorw;
  assign rd_en       = iocs & iorw;
  assign rd_data_sel = rd_en & (ioaddr == ADDR_DATA);
  assign rd_stat_sel = rd_en & (ioaddr == ADDR_STAT);

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      TX_EMPTY: begin
        if (wr_en && ioaddr == ADDR_DATA) begin
          tx_data_d = databus;
          state_d   = TX_LOADED;
        end
      end
      TX_LOADED: begin
        if (!tx_busy) state_d = TX_ISSUE;
      end
      TX_ISSUE: state_d = TX_EMPTY;
      default:  state_d = TX_EMPTY;
    endcase
  end

  // A new byte landing on an unread one is an overrun,
  // and the set takes priority over the status-read clear.
  always_comb begin
    ovr_set = rx_valid & rda_q;
    rxbuf_d = rx_valid ? rx_data : rxbuf_q;
    rda_d   = rda_q;
    ovr_d   = ovr_q;
    if (rx_valid) begin
      rda_d = 1'b1;
    end else if (rd_data_sel) begin
      rda_d = 1'b0;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (rd_stat_sel) begin
      ovr_d = 1'b0;
    end
  end

  always_comb begin
    div_d  = div_q;
    reload = 1'b0;
    if (wr_en) begin
      unique case (1'b1)
        ioaddr == ADDR_DIVL: begin
          div_d[7:0] = databus;
          reload     = 1'b1;
        end
        ioaddr == ADDR_DIVH: begin
          div_d[15:8] = databus;
          reload      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_EMPTY;
      tx_data_q <= 8'h00;
      rxbuf_q   <= 8'h00;
      rda_q     <= 1'b0;
      ovr_q     <= 1'b0;
      div_q     <= DIV_DEFAULT;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rxbuf_q   <= rxbuf_d;
      rda_q     <= rda_d;
      ovr_q     <= ovr_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      ADDR_DATA: rd_data = rxbuf_q;
      ADDR_STAT: rd_data = status_byte(ovr_q, tbr, rda_q);
      ADDR_DIVL: rd_data = div_q[7:0];
      ADDR_DIVH: rd_data = div_q[15:8];
      default:   rd_data = 8'h00;
    endcase
  end

  assign databus  = rd_en ? rd_data : 8'hzz;
  assign tbr      = (state_q == TX_EMPTY);
  assign tx_start = (state_q == TX_ISSUE);
  assign tx_data  = tx_data_q;
  assign rda      = rda_q;

  spart_baud_gen u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .divisor_i (div_d),
    .reload_i  (reload),
    .baud_en_o (baud_en)
  );

endmodule

// File: tb/tb_spart_bus_if.sv
// Self-checking bench for spart_bus_if: bus-op tables
// plus a TX scoreboard fed at write time, drained on tx_start.
module tb_spart_bus_if;

  logic       clk;
  logic       rst_n;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       baud_en;

  logic       db_oe;
  logic [7:0] db_drv;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int starts = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic       cs;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       rxv;
    logic [7:0] rxd;
    logic [7:0] exp;
    string      name;
  } op_t;

  op_t tbl[$];

  assign databus = db_oe ? db_drv : 8'hzz;

  spart_bus_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_en  (baud_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard drain: every tx_start must match the oldest accepted byte.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      starts++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_start_unexpected: got tx_data %0h want none", tx_data);
      end else begin
        chk("tx_data_sb", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  function automatic op_t rd_op(string n, logic [1:0] a, logic [7:0] e,
                                logic v = 1'b0, logic [7:0] d = 8'h00);
    op_t o;
    o.cs = 1'b1; o.rd = 1'b1; o.addr = a; o.wd = 8'h00;
    o.rxv = v; o.rxd = d; o.exp = e; o.name = n;
    return o;
  endfunction

  function automatic op_t wr_op(string n, logic [1:0] a, logic [7:0] w);
    op_t o;
    o.cs = 1'b1; o.rd = 1'b0; o.addr = a; o.wd = w;
    o.rxv = 1'b0; o.rxd = 8'h00; o.exp = 8'h00; o.name = n;
    return o;
  endfunction

  // Idle cycle: bench drives 8'h00 on the bus; any DUT drive corrupts it.
  function automatic op_t idle_op(string n, logic v, logic [7:0] d);
    op_t o;
    o.cs = 1'b0; o.rd = 1'b1; o.addr = 2'd2; o.wd = 8'h00;
    o.rxv = v; o.rxd = d; o.exp = 8'h00; o.name = n;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(op_t o);
    iocs     = o.cs;
    iorw     = o.rd;
    ioaddr   = o.addr;
    rx_valid = o.rxv;
    rx_data  = o.rxd;
    db_oe    = !(o.cs && o.rd);
    db_drv   = o.cs ? o.wd : 8'h00;
    #2;
    if (o.rd) chk(o.name, {24'h0, databus}, {24'h0, o.exp});
    tick();
    iocs     = 1'b0;
    iorw     = 1'b1;
    rx_valid = 1'b0;
    db_oe    = 1'b1;
    db_drv   = 8'h00;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) do_op(tbl[i]);
    tbl.delete();
  endtask

  task automatic bus_wr(logic [1:0] a, logic [7:0] w);
    do_op(wr_op("wr", a, w));
  endtask

  task automatic wait_baud(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (baud_en) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  s0, c1, c2, ones;
    bit  ok1, ok2, seen;

    rst_n = 1'b0; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'd0;
    tx_busy = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    db_oe = 1'b1; db_drv = 8'h00;
    #23;
    chk("rst_tbr", tbr, 1);
    chk("rst_rda", rda, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_baud_en", baud_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    tbl.push_back(rd_op("rst_status", 2'd1, 8'h02));
    tbl.push_back(rd_op("rst_divl", 2'd2, 8'h44));
    tbl.push_back(rd_op("rst_divh", 2'd3, 8'h01));
    tbl.push_back(rd_op("rst_rxbuf", 2'd0, 8'h00));
    tbl.push_back(idle_op("idle_hiz", 1'b0, 8'h00));
    tbl.push_back(wr_op("wr_stat", 2'd1, 8'hFF));
    tbl.push_back(rd_op("stat_after_wr1", 2'd1, 8'h02));
    run_tbl();

    // Basic transmit: 2-cycle write to tx_start latency.
    sb.push_back(8'hA5);
    bus_wr(2'd0, 8'hA5);
    chk("tx1_tbr_low", tbr, 0);
    chk("tx1_loaded_nostart", tx_start, 0);
    tick();
    chk("tx1_start", tx_start, 1);
    chk("tx1_data", {24'h0, tx_data}, 32'hA5);
    tick();
    chk("tx1_tbr_back", tbr, 1);
    chk("tx1_start_done", tx_start, 0);

    // Serializer busy: second write dropped, first byte held.
    tx_busy = 1'b1;
    sb.push_back(8'hA5);
    bus_wr(2'd0, 8'hA5);
    bus_wr(2'd0, 8'h3C);
    s0 = starts;
    repeat (10) tick();
    chk("busy_no_start", starts, s0);
    chk("busy_data_kept", {24'h0, tx_data}, 32'hA5);
    chk("busy_tbr_low", tbr, 0);
    tx_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (starts != s0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("busy_start_after_fall", seen, 1);
    tick();
    chk("busy_tbr_back", tbr, 1);
    chk("sb_empty_tx", sb.size(), 0);

    // Receive: overrun, read clears, coincident rx/read, set-wins.
    tbl.push_back(idle_op("rx11", 1'b1, 8'h11));
    tbl.push_back(idle_op("rx22", 1'b1, 8'h22));
    tbl.push_back(rd_op("ovr_status", 2'd1, 8'h07));
    tbl.push_back(rd_op("rd_22", 2'd0, 8'h22));
    tbl.push_back(rd_op("status_clear", 2'd1, 8'h02));
    tbl.push_back(idle_op("rx33", 1'b1, 8'h33));
    tbl.push_back(rd_op("status_rda", 2'd1, 8'h03));
    tbl.push_back(rd_op("rd_33_rx44", 2'd0, 8'h33, 1'b1, 8'h44));
    tbl.push_back(rd_op("status_after_coinc", 2'd1, 8'h07));
    tbl.push_back(rd_op("rd_44", 2'd0, 8'h44));
    tbl.push_back(rd_op("status_empty", 2'd1, 8'h02));
    tbl.push_back(idle_op("rx55", 1'b1, 8'h55));
    tbl.push_back(idle_op("rx66", 1'b1, 8'h66));
    tbl.push_back(rd_op("stat_rx77", 2'd1, 8'h07, 1'b1, 8'h77));
    tbl.push_back(rd_op("ovr_set_wins", 2'd1, 8'h07));
    tbl.push_back(rd_op("rd_77", 2'd0, 8'h77));
    tbl.push_back(rd_op("status_final", 2'd1, 8'h02));
    run_tbl();

    // Baud: divisor 0x0050 -> 81-cycle period, then divisor 0.
    bus_wr(2'd2, 8'h50);
    bus_wr(2'd3, 8'h00);
    wait_baud(c1, ok1);
    wait_baud(c2, ok2);
    chk("baud_seen", {30'h0, ok1, ok2}, 32'h3);
    chk("baud_period_81", c2 - c1, 81);
    bus_wr(2'd2, 8'h00);
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (baud_en) ones++;
    end
    chk("baud_div0_every", ones, 5);
    tbl.push_back(rd_op("divl_0", 2'd2, 8'h00));
    tbl.push_back(rd_op("divh_0", 2'd3, 8'h00));
    run_tbl();

    // Reset while a byte is held: no tx_start, tbr back at once.
    tx_busy = 1'b1;
    bus_wr(2'd0, 8'h99);
    chk("mid_tbr_low", tbr, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tbr", tbr, 1);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    s0 = starts;
    repeat (2) tick();
    rst_n   = 1'b1;
    tx_busy = 1'b0;
    repeat (6) tick();
    chk("mid_no_start", starts, s0);
    tbl.push_back(rd_op("post_rst_status", 2'd1, 8'h02));
    tbl.push_back(rd_op("post_rst_divl", 2'd2, 8'h44));
    run_tbl();
    chk("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
